// File: rtl/ysyx_22040000_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings (funct3 order),
// FSM state constants and op classification helpers.
package ysyx_22040000_mdu_pkg;

    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_CALC = 2'd1;
    localparam mdu_state_t ST_DONE = 2'd2;

    function automatic logic mdu_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

    // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
    function automatic logic mdu_is_signed_a(input logic [MDU_OP_WIDTH-1:0] op);
        return (op == MDU_MULH) | (op == MDU_MULHSU) | (op == MDU_DIV) | (op == MDU_REM);
    endfunction

    function automatic logic mdu_is_signed_b(input logic [MDU_OP_WIDTH-1:0] op);
        return (op == MDU_MULH) | (op == MDU_DIV) | (op == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_22040000_mdu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, DWIDTH steps.
// o_last flags the step that produces the final quotient/remainder on o_*_nxt.
module ysyx_22040000_mdu_divider
    import ysyx_22040000_mdu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = $clog2(DWIDTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              i_start,
    input  logic [DWIDTH-1:0] i_dividend,
    input  logic [DWIDTH-1:0] i_divisor,
    output logic              o_last,
    output logic [DWIDTH-1:0] o_quo_nxt,
    output logic [DWIDTH-1:0] o_rem_nxt
);

    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [DWIDTH-1:0] r_rem;
    logic [DWIDTH-1:0] r_quo;
    logic [DWIDTH-1:0] r_dvs;

    logic [DWIDTH:0]   w_shift;
    logic [DWIDTH:0]   w_diff;
    logic              w_ge;

    // One restoring step: shift in the next dividend bit and trial-subtract
    always_comb begin
        w_shift   = {r_rem, r_quo[DWIDTH-1]};
        w_diff    = w_shift - {1'b0, r_dvs};
        w_ge      = ~w_diff[DWIDTH];
        o_rem_nxt = w_ge ? w_diff[DWIDTH-1:0] : w_shift[DWIDTH-1:0];
        o_quo_nxt = {r_quo[DWIDTH-2:0], w_ge};
        o_last    = r_busy & (r_cnt == CNT_W'(DWIDTH - 1));
    end

    // Divider state: load on start, iterate while busy, abort on flush
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
            r_rem  <= {DWIDTH{1'b0}};
            r_quo  <= {DWIDTH{1'b0}};
            r_dvs  <= {DWIDTH{1'b0}};
        end else if (flush) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= {CNT_W{1'b0}};
            r_rem  <= {DWIDTH{1'b0}};
            r_quo  <= i_dividend;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_rem  <= o_rem_nxt;
            r_quo  <= o_quo_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22040000_mdu.sv
// RV32M/RV64M multiply/divide unit with valid/ready handshake and flush.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
module ysyx_22040000_mdu
    import ysyx_22040000_mdu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = $clog2(DWIDTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MDU_OP_WIDTH-1:0] op,
    input  logic [DWIDTH-1:0]       a,
    input  logic [DWIDTH-1:0]       b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DWIDTH-1:0]       result,
    output logic                    busy
);

    localparam int DW2 = 2 * DWIDTH;
    localparam logic [DWIDTH-1:0] W_MIN  = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] W_ONES = {DWIDTH{1'b1}};

    mdu_state_t              r_state;
    mdu_state_t              w_state_nxt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;
    logic [MDU_OP_WIDTH-1:0] r_op;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic [CNT_W-1:0]        r_cnt;
    logic [DW2-1:0]          r_acc;
    logic [DWIDTH-1:0]       r_mcand;
    logic [DWIDTH-1:0]       r_result;

    logic                    w_accept;
    logic                    w_sa;
    logic                    w_sb;
    logic [DWIDTH-1:0]       w_a_mag;
    logic [DWIDTH-1:0]       w_b_mag;
    logic                    w_b_zero;
    logic                    w_ovf;
    logic                    w_special;
    logic [DWIDTH-1:0]       w_special_res;
    logic                    w_fast_mul;
    logic [DWIDTH-1:0]       w_fast_res;
    logic                    w_direct;
    logic [DWIDTH-1:0]       w_direct_res;
    logic [DWIDTH:0]         w_mul_sum;
    logic [DW2-1:0]          w_acc_nxt;
    logic                    w_calc_last;
    logic [DWIDTH-1:0]       w_calc_res;
    logic                    w_div_start;
    logic                    w_div_last;
    logic [DWIDTH-1:0]       w_quo_nxt;
    logic [DWIDTH-1:0]       w_rem_nxt;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

    function automatic logic [DWIDTH-1:0] fix_mul(input logic [MDU_OP_WIDTH-1:0] f,
                                                  input logic neg,
                                                  input logic [DW2-1:0] p);
        logic [DW2-1:0] s;
        s = neg ? (~p + DW2'(1)) : p;
        return (f == MDU_MUL) ? s[DWIDTH-1:0] : s[DW2-1:DWIDTH];
    endfunction

    // REM/REMU have op[1] set; remainder follows the dividend's sign
    function automatic logic [DWIDTH-1:0] fix_div(input logic [MDU_OP_WIDTH-1:0] f,
                                                  input logic neg_q,
                                                  input logic neg_r,
                                                  input logic [DWIDTH-1:0] q,
                                                  input logic [DWIDTH-1:0] r);
        if (f[1]) begin
            return neg_r ? (~r + DWIDTH'(1)) : r;
        end else begin
            return neg_q ? (~q + DWIDTH'(1)) : q;
        end
    endfunction

    // Request decode: operand magnitudes, signs and the cases that skip CALC
    always_comb begin
        w_accept = in_valid & r_in_ready & ~flush;
        w_sa     = mdu_is_signed_a(op) & a[DWIDTH-1];
        w_sb     = mdu_is_signed_b(op) & b[DWIDTH-1];
        w_a_mag  = w_sa ? (~a + DWIDTH'(1)) : a;
        w_b_mag  = w_sb ? (~b + DWIDTH'(1)) : b;
        w_b_zero = mdu_is_div(op) & (b == {DWIDTH{1'b0}});
        w_ovf    = ((op == MDU_DIV) | (op == MDU_REM)) & (a == W_MIN) & (b == W_ONES);
        w_special = w_b_zero | w_ovf;
        if (w_b_zero) begin
            w_special_res = op[1] ? a : W_ONES;
        end else if (w_ovf) begin
            w_special_res = op[1] ? {DWIDTH{1'b0}} : W_MIN;
        end else begin
            w_special_res = {DWIDTH{1'b0}};
        end
    end

`ifdef MDU_FAST_MUL_EN
    // Single-cycle product of the magnitudes, sign-fixed like the iterative path
    always_comb begin
        w_fast_mul = ~mdu_is_div(op);
        w_fast_res = fix_mul(op, w_sa ^ w_sb,
                             {{DWIDTH{1'b0}}, w_a_mag} * {{DWIDTH{1'b0}}, w_b_mag});
    end
`else
    // Multiplies always take the iterative path in this build
    always_comb begin
        w_fast_mul = 1'b0;
        w_fast_res = {DWIDTH{1'b0}};
    end
`endif

    // Shift-add multiply step and selection of the finished result
    always_comb begin
        w_direct     = w_special | w_fast_mul;
        w_direct_res = w_special ? w_special_res : w_fast_res;
        w_mul_sum    = {1'b0, r_acc[DW2-1:DWIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(DWIDTH+1){1'b0}});
        w_acc_nxt    = {w_mul_sum, r_acc[DWIDTH-1:1]};
        w_div_start  = w_accept & mdu_is_div(op) & ~w_special;
        if (mdu_is_div(r_op)) begin
            w_calc_last = w_div_last;
            w_calc_res  = fix_div(r_op, r_neg_q, r_neg_r, w_quo_nxt, w_rem_nxt);
        end else begin
            w_calc_last = (r_cnt == CNT_W'(DWIDTH - 1));
            w_calc_res  = fix_mul(r_op, r_neg_q, w_acc_nxt);
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = w_accept ? (w_direct ? ST_DONE : ST_CALC) : ST_IDLE;
                ST_CALC: w_state_nxt = w_calc_last ? ST_DONE : ST_CALC;
                ST_DONE: w_state_nxt = out_ready ? ST_IDLE : ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and handshake outputs, registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Datapath: latch the request on accept, iterate in CALC, capture the result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op     <= MDU_MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {DW2{1'b0}};
            r_mcand  <= {DWIDTH{1'b0}};
            r_result <= {DWIDTH{1'b0}};
        end else if (w_accept) begin
            r_op     <= op;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {{DWIDTH{1'b0}}, w_a_mag};
            r_mcand  <= w_b_mag;
            if (w_direct) begin
                r_result <= w_direct_res;
            end
        end else if ((r_state == ST_CALC) && !flush) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc_nxt;
            if (w_calc_last) begin
                r_result <= w_calc_res;
            end
        end
    end

    ysyx_22040000_mdu_divider #(
        .DWIDTH (DWIDTH),
        .CNT_W  (CNT_W)
    ) u_divider (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .i_start    (w_div_start),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_last     (w_div_last),
        .o_quo_nxt  (w_quo_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

endmodule

// File: tb/tb_ysyx_22040000_mdu.sv
// Self-checking bench for ysyx_22040000_mdu (DWIDTH=32): directed plan vectors,
// randomized ops against an arithmetic reference, backpressure, flush and reset.
module tb_ysyx_22040000_mdu;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22040000_mdu #(.DWIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clock = ~clock;

    // RISC-V M-extension semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'd0;
        case (f)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'd0, y}); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return MIN32;
                p = sx / sy; return p[31:0];
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 32'd0 || ((f == 3'd4 || f == 3'd6) && x == MIN32 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    // Present one request, then scramble inputs and count cycles to out_valid
    task automatic issue_and_wait(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] res, output int lat, output bit ok);
        @(negedge clock);
        in_valid = 1'b1; op = f; a = x; b = y;
        @(posedge clock); #1;
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0; ok = 1'b0;
        while (lat < 100 && !ok) begin
            @(negedge clock);
            lat++;
            if (out_valid) ok = 1'b1;
        end
        res = result;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_res);
        logic [31:0] res;
        int lat, el;
        bit ok;
        el = exp_lat(f, x, y);
        issue_and_wait(f, x, y, res, lat, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid not seen within %0d cycles", name, lat);
        end else begin
            if (res !== exp_res) begin
                n_fail++;
                $display("FAIL %s result: got %h expected %h (op=%0d a=%h b=%h)", name, res, exp_res, f, x, y);
            end
            n_checks++;
            if (lat !== el) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, el);
            end
            release_result();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h expected 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  fv [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] av [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'h1234, 32'h1234, 32'h1234, 32'h1234, MIN32, MIN32};
        logic [31:0] bv [14] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [14] = '{32'h2A, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 32'h1234, MIN32, 32'd0};
        for (int i = 0; i < 14; i++) begin
            check_op($sformatf("directed[%0d]", i), fv[i], av[i], bv[i], ev[i]);
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] x, y;
        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = MIN32; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 50); end
                3: begin x = -($urandom_range(0, 1000)); y = $urandom_range(1, 50); end
                default: ;
            endcase
            check_op($sformatf("random[%0d]", i), f, x, y, ref_model(f, x, y));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, x, y, exp_res;
        int lat, bad;
        bit ok;
        x = $urandom; y = $urandom;
        exp_res = ref_model(3'd1, x, y);
        issue_and_wait(3'd1, x, y, res, lat, ok);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (result !== exp_res || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            @(negedge clock);
        end
        n_checks++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: ok=%b unstable_cycles=%0d result=%h expected %h", ok, bad, result, exp_res);
        end
        release_result();
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_ready_after: in_ready=%b expected 1", in_ready);
        end
        check_op("backpressure_next", 3'd5, 32'd1000, 32'd9, 32'd111);
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clock);
        in_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc: out_valid=%b in_ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clock); if (out_valid) seen = 1'b1; end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_no_result: out_valid seen=%b expected 0", seen);
        end
        check_op("flush_then_mul", 3'd0, 32'd3, 32'd5, 32'd15);
        // Flush together with a request in IDLE: nothing is accepted
        @(negedge clock);
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clock); if (out_valid || busy || !in_ready) seen = 1'b1; end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_idle: request accepted=%b expected 0", seen);
        end
    endtask

    task automatic test_flush_done_and_reset();
        logic [31:0] res;
        int lat;
        bit ok;
        issue_and_wait(3'd7, 32'd50, 32'd0, res, lat, ok);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (!ok || res !== 32'd50 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: ok=%b result=%h out_valid=%b in_ready=%b expected 1 32 0 1",
                     ok, res, out_valid, in_ready);
        end
        // Reset mid-divide clears the held result as well as the FSM
        in_valid = 1'b1; op = 3'd5; a = 32'd77; b = 32'd5;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (result !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: result=%h out_valid=%b in_ready=%b busy=%b expected 0 0 1 0",
                     result, out_valid, in_ready, busy);
        end
        check_op("after_reset", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_flush_done_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040000_mdu.md
Name: ysyx_22040000_mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M/RV64M integer ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU in EXU; EXU dispatches M-extension ops here over a valid/ready handshake and stalls until the result returns.
- Parametrised in operand width; one operation in flight at a time; abortable by pipeline flush.

Parameters:
- DWIDTH, 32, operand/result width in bits (32 or 64); must be even and >= 8.
- CNT_W, $clog2(DWIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort any in-flight op; result discarded
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  MDU_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7 (funct3 encoding)
- a  in  DWIDTH  rs1 operand
- b  in  DWIDTH  rs2 operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DWIDTH  operation result
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0.
- Accept: in_valid & in_ready in IDLE. On accept, latch op; take magnitudes of a and b for signed operands (MULH: both; MULHSU: a only; DIV/REM: both); record the result sign; go to CALC; counter=0.
- in_ready=1 only in IDLE. No request overlaps a held result.
- Multiply: radix-2 shift-add on a 2*DWIDTH accumulator, one bit per cycle, DWIDTH cycles in CALC. Negate the full 2*DWIDTH product if the sign flag is set. MUL returns the low DWIDTH bits; MULH/MULHSU/MULHU return the high DWIDTH bits.
- Divide: restoring, one quotient bit per cycle, DWIDTH cycles. Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Latency: normal ops assert out_valid exactly DWIDTH+1 cycles after the accept edge (CALC→DONE when counter==DWIDTH-1).
- Special cases skip CALC and go IDLE→DONE, with out_valid 1 cycle after accept:
  - b==0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a==MIN, b==-1) for DIV → MIN; for REM → 0.
- DONE: out_valid=1; result stable until out_ready. The cycle with out_valid & out_ready returns to IDLE, so in_ready=1 on the next cycle.
- Flush: any state → IDLE on the next edge; out_valid=0 next cycle; no result emitted. Flush with in_valid in IDLE: flush wins, no accept. Flush in DONE with out_ready the same cycle: the handshake completes (result consumed), then IDLE.
- Reset mid-op behaves identically to flush and additionally clears result to 0.
- Inputs a/b/op are sampled only at accept; changes while busy are ignored.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational DWIDTH×DWIDTH product. Result registers in IDLE→DONE, so out_valid comes 1 cycle after accept. Divide is unchanged.
- Undefined: iterative multiply as above. In both builds, results are bit-identical for all inputs.

Decomposition:
- Shared package/header holds:
  - MDU op encodings (MDU_MUL..MDU_REMU) and MDU_OP_WIDTH=3.
  - FSM state typedef (IDLE/CALC/DONE).
  - MDU_IS_DIV(op)=op[2] and MDU_IS_SIGNED helpers.
- One sub-module is natural: ysyx_22040000_mdu_divider, the iterative restoring divide core with start/done. The top-level handles sign fix-up, special cases, multiply and handshake.

Test Plan (DWIDTH=32):
- MUL a=7, b=6 → result 0x0000002A; out_valid exactly 33 cycles after accept.
- MULH a=0xFFFFFFFF (-1), b=0xFFFFFFFF; MULHSU same; MULHU same → 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV/REM/DIVU/REMU with b=0, a=0x1234 → 0xFFFFFFFF, 0x1234, 0xFFFFFFFF, 0x1234. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 and REM → 0. All special cases give out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable and in_ready=0 throughout. The next request is accepted the cycle after the handshake.
- Flush at cycle 5 of a DIV → no out_valid; in_ready=1 next cycle. A new MUL 3×5 then returns 15. Flush with in_valid in IDLE → no accept.
